// File: rtl/bwt_pkg.sv
// Shared types and defaults for the streaming Burrows-Wheeler transform block.
package bwt_pkg;

    localparam int DEF_CHAR_W  = 8;
    localparam int DEF_MAX_LEN = 128;

    // Width of length-1 / index fields for a given maximum string length.
    function automatic int idx_w(input int max_len);
        return $clog2(max_len);
    endfunction

    typedef logic [DEF_CHAR_W-1:0] char_t;
    typedef char_t str_t [DEF_MAX_LEN];

    typedef enum logic [1:0] {LOAD, SORT, SEND} state_t;
    typedef enum logic       {C_IDLE, C_CMP}    core_state_t;

endpackage

// File: rtl/bwt_sort_core.sv
// Rank-counting BWT sorter.
// For every rotation i, it counts the rotations that sort before i. It compares them
// one character per cycle, so latency depends on the data. Ties between equal
// rotations are broken by start offset. The rank of rotation i is where its last
// character lands in bwt.
module bwt_sort_core
    import bwt_pkg::*;
#(
    parameter  int CHAR_W  = DEF_CHAR_W,
    parameter  int MAX_LEN = DEF_MAX_LEN,
    localparam int IDX_W   = idx_w(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  len,
    input  logic [CHAR_W-1:0] str [MAX_LEN],
    output logic              done,
    output logic [CHAR_W-1:0] bwt [MAX_LEN],
    output logic [IDX_W-1:0]  prim,
    output core_state_t       dbg_state
);

    core_state_t      state;
    logic [IDX_W-1:0] i, j, k, pi, pj, cnt;

    logic [CHAR_W-1:0] ci, cj;
    logic              same, resolved, inc;
    logic [IDX_W-1:0]  cnt_nxt, pi_nxt, pj_nxt, last_src;

    assign dbg_state = state;

    // Compare one character of rotation j against rotation i, and decide whether j ranks below i.
    always_comb begin
        ci       = str[pi];
        cj       = str[pj];
        same     = (j == i);
        resolved = same || (cj != ci) || (k == len);
        inc      = !same && ((cj < ci) || ((cj == ci) && (k == len) && (j < i)));
        cnt_nxt  = cnt + {{(IDX_W-1){1'b0}}, inc};
        pi_nxt   = (pi == len) ? '0 : pi + 1'b1;
        pj_nxt   = (pj == len) ? '0 : pj + 1'b1;
        last_src = (i == '0) ? len : i - 1'b1;
    end

    // Walk the (i, j, k) loops. Rotation i's rank is final once j has passed len.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= C_IDLE;
            done  <= 1'b0;
            prim  <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            pi    <= '0;
            pj    <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                C_IDLE: begin
                    if (start) begin
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        pi    <= '0;
                        pj    <= '0;
                        cnt   <= '0;
                        state <= C_CMP;
                    end
                end
                C_CMP: begin
                    if (!resolved) begin
                        k  <= k + 1'b1;
                        pi <= pi_nxt;
                        pj <= pj_nxt;
                    end else if (j == len) begin
                        bwt[cnt_nxt] <= str[last_src];
                        if (i == '0)
                            prim <= cnt_nxt;
                        if (i == len) begin
                            done  <= 1'b1;
                            state <= C_IDLE;
                        end else begin
                            i   <= i + 1'b1;
                            pi  <= i + 1'b1;
                            j   <= '0;
                            pj  <= '0;
                            k   <= '0;
                            cnt <= '0;
                        end
                    end else begin
                        j   <= j + 1'b1;
                        pj  <= j + 1'b1;
                        pi  <= i;
                        k   <= '0;
                        cnt <= cnt_nxt;
                    end
                end
                default: state <= C_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bwt_stream_top.sv
// Streaming BWT wrapper. It loads a string, sorts it with bwt_sort_core, then
// streams out the BWT with the primary index on every beat.
// Handshake rule on both ports: a beat transfers on a rising clk edge where
// valid & ready are both high. Once valid is raised, the source holds
// data/last/index stable until that transfer.
module bwt_stream_top
    import bwt_pkg::*;
#(
    parameter  int CHAR_W  = DEF_CHAR_W,
    parameter  int MAX_LEN = DEF_MAX_LEN,
    localparam int IDX_W   = idx_w(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CHAR_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CHAR_W-1:0] m_data,
    output logic              m_last,
    output logic [IDX_W-1:0]  m_index,
    output logic              busy,
    output logic              err_ovf,
    output state_t            dbg_state
);

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(MAX_LEN);

    state_t            state;
    logic [IDX_W:0]    wr_ptr;
    logic              drop;
    logic [IDX_W-1:0]  len;
    logic [IDX_W-1:0]  out_ptr;
    logic [IDX_W-1:0]  nxt_ptr;
    logic [CHAR_W-1:0] str_buf [MAX_LEN];
    logic              core_start, core_done;
    logic [CHAR_W-1:0] core_bwt [MAX_LEN];
    logic [IDX_W-1:0]  core_prim;
    core_state_t       core_dbg;
    logic              in_beat, wr_en;

    assign dbg_state = state;
    assign in_beat   = s_valid && s_ready;
    assign wr_en     = in_beat && !drop && (wr_ptr != FULL);
    assign nxt_ptr   = out_ptr + 1'b1;

    // Input buffer. It is written only with in-range beats of a string that is not being dropped.
    always_ff @(posedge clk) begin
        if (wr_en)
            str_buf[wr_ptr[IDX_W-1:0]] <= s_data;
    end

    // Main FSM. It handles load and overflow tracking, core launch, and the registered output sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            drop       <= 1'b0;
            len        <= '0;
            out_ptr    <= '0;
            s_ready    <= 1'b1;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            m_index    <= '0;
            busy       <= 1'b0;
            err_ovf    <= 1'b0;
            core_start <= 1'b0;
        end else begin
            err_ovf    <= 1'b0;
            core_start <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_beat) begin
                        if (drop || wr_ptr == FULL) begin
                            // Overlong string: swallow beats until its s_last beat.
                            if (s_last) begin
                                err_ovf <= 1'b1;
                                drop    <= 1'b0;
                                wr_ptr  <= '0;
                            end else begin
                                drop <= 1'b1;
                            end
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (s_last) begin
                                len     <= wr_ptr[IDX_W-1:0];
                                s_ready <= 1'b0;
                                busy    <= 1'b1;
                                if (wr_ptr == '0) begin
                                    // A single character is its own BWT. No sort is needed.
                                    state   <= SEND;
                                    out_ptr <= '0;
                                    m_valid <= 1'b1;
                                    m_data  <= s_data;
                                    m_last  <= 1'b1;
                                    m_index <= '0;
                                end else begin
                                    state      <= SORT;
                                    core_start <= 1'b1;
                                end
                            end
                        end
                    end
                end
                SORT: begin
                    if (core_done) begin
                        state   <= SEND;
                        out_ptr <= '0;
                        m_valid <= 1'b1;
                        m_data  <= core_bwt[0];
                        m_last  <= 1'b0;
                        m_index <= core_prim;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            wr_ptr  <= '0;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            out_ptr <= nxt_ptr;
                            m_data  <= core_bwt[nxt_ptr];
                            m_last  <= (nxt_ptr == len);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    bwt_sort_core #(
        .CHAR_W (CHAR_W),
        .MAX_LEN(MAX_LEN)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (core_start),
        .len      (len),
        .str      (str_buf),
        .done     (core_done),
        .bwt      (core_bwt),
        .prim     (core_prim),
        .dbg_state(core_dbg)
    );

endmodule
